// File: rtl/onn_phase_readout.sv
// Convergence monitor for the ONN phase bus: waits for a steady run, decodes the
// 15 phases into a binary pattern relative to neuron 0, then shifts it out LSB first.
module onn_phase_readout #(
    parameter int STABLE_CYCLES = 8,
    parameter int MAX_CYCLES    = 1000
) (
    input  logic        sclk,
    input  logic        re,
    input  logic        arm,
    input  logic [0:59] phi_in,
    input  logic        steady_in,
    input  logic        incons_in,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [1:0]  fail_code,
    output logic [14:0] pattern,
    output logic [15:0] conv_cycles,
    output logic        sout,
    output logic        sout_valid
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DUMP = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    localparam logic [7:0]  STABLE_LIM = 8'(STABLE_CYCLES);
    localparam logic [15:0] CYC_LAST   = 16'(MAX_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cyc_q, cyc_d;
    logic [7:0]  run_q, run_d;
    logic [7:0]  run_next;
    logic [14:0] pattern_q, pattern_d;
    logic [15:0] conv_q, conv_d;
    logic [1:0]  code_q, code_d;
    logic [14:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;

    // Phase k occupies phi_in[4k:4k+3] with the lowest index as MSB.
    logic [3:0]  phase [15];
    logic [14:0] decoded;

    for (genvar gi = 0; gi < 15; gi++) begin : g_phase
        assign phase[gi] = phi_in[4*gi +: 4];
    end

    assign decoded[0] = 1'b0;
    for (genvar gi = 1; gi < 15; gi++) begin : g_decode
        logic [3:0] diff;
        assign diff        = phase[gi] - phase[0];
        assign decoded[gi] = (diff >= 4'd4) && (diff <= 4'd11);
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        run_d     = run_q;
        pattern_d = pattern_q;
        conv_d    = conv_q;
        code_d    = code_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        run_next  = steady_in ? run_q + 8'd1 : 8'd0;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (arm) begin
                    state_d   = S_WAIT;
                    cyc_d     = 16'd0;
                    run_d     = 8'd0;
                    pattern_d = 15'd0;
                    conv_d    = 16'd0;
                    code_d    = 2'b00;
                end
            end
            S_WAIT: begin
                // Inconsistency beats convergence, which beats timeout.
                if (incons_in) begin
                    state_d = S_FAIL;
                    code_d  = 2'b01;
                end else if (run_next == STABLE_LIM) begin
                    pattern_d = decoded;
                    conv_d    = cyc_q;
                    shift_d   = decoded;
                    cnt_d     = 4'd0;
                    state_d   = S_DUMP;
                end else if (cyc_q == CYC_LAST) begin
                    state_d = S_FAIL;
                    code_d  = 2'b10;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                    run_d = run_next;
                end
            end
            S_DUMP: begin
                if (cnt_q == 4'd14) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    shift_d = {1'b0, shift_q[14:1]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (re) begin
            state_q   <= S_IDLE;
            cyc_q     <= 16'd0;
            run_q     <= 8'd0;
            pattern_q <= 15'd0;
            conv_q    <= 16'd0;
            code_q    <= 2'b00;
            shift_q   <= 15'd0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            run_q     <= run_d;
            pattern_q <= pattern_d;
            conv_q    <= conv_d;
            code_q    <= code_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy        = (state_q == S_WAIT) || (state_q == S_DUMP);
    assign done        = (state_q == S_DONE);
    assign fail        = (state_q == S_FAIL);
    assign fail_code   = code_q;
    assign pattern     = pattern_q;
    assign conv_cycles = conv_q;
    assign sout_valid  = (state_q == S_DUMP);
    assign sout        = sout_valid & shift_q[0];

endmodule
